// File: rtl/orsram_rd_ctrl_if.sv
// ---------------------------------------------------------------------------
// orsram_rd_ctrl_if
// Bundles the two buses the orsram read sequencer owns:
//   - the SRAM bank control/data port (sram_CEN, sram_WEN, sram_A, sram_Q)
//   - the outgoing word stream (out_valid, out_ready, out_data[, out_last])
// modport master : the sequencer side (drives SRAM control and the stream)
// modport slave  : the peer side (SRAM bank returning Q, downstream sink)
// Optional macro ORSRAM_RD_LAST_EN adds out_last to the stream.
// ---------------------------------------------------------------------------
`ifndef SRAM_NUM
`define SRAM_NUM 8
`endif

interface orsram_rd_ctrl_if #(
  parameter int BANK_NUM = `SRAM_NUM,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8
);
  logic                       sram_CEN;
  logic [BANK_NUM-1:0]        sram_WEN;
  logic [BANK_NUM*ADDR_W-1:0] sram_A;
  logic [BANK_NUM*DATA_W-1:0] sram_Q;
  logic                       out_valid;
  logic                       out_ready;
  logic [BANK_NUM*DATA_W-1:0] out_data;
`ifdef ORSRAM_RD_LAST_EN
  logic                       out_last;

  modport master (
    output sram_CEN, sram_WEN, sram_A,
    input  sram_Q,
    output out_valid, out_data, out_last,
    input  out_ready
  );

  modport slave (
    input  sram_CEN, sram_WEN, sram_A,
    output sram_Q,
    input  out_valid, out_data, out_last,
    output out_ready
  );
`else
  modport master (
    output sram_CEN, sram_WEN, sram_A,
    input  sram_Q,
    output out_valid, out_data,
    input  out_ready
  );

  modport slave (
    input  sram_CEN, sram_WEN, sram_A,
    output sram_Q,
    input  out_valid, out_data,
    output out_ready
  );
`endif
endinterface

// File: rtl/orsram_rd_ctrl.sv
// ---------------------------------------------------------------------------
// orsram_rd_ctrl
// Read-side sequencer for the output-result SRAM bank. After an accepted
// start it walks len consecutive addresses from base_addr (wrapping modulo
// 2^ADDR_W), reads all banks in parallel and streams one concatenated word
// per address through a 2-entry skid FIFO with full backpressure support.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           one-cycle burst request, accepted only in IDLE
//   base_addr, len  burst start address and word count (0..2^ADDR_W)
//   busy            high from the accepted start until the last handoff
//   done            one-cycle pulse when the burst completes
//   bus (master)    SRAM control/Q port and out_valid/out_ready/out_data
//
// Optional macro ORSRAM_RD_LAST_EN: tags the final word of each burst with
// out_last (carried through the FIFO next to the data).
// ---------------------------------------------------------------------------
`ifndef SRAM_NUM
`define SRAM_NUM 8
`endif

module orsram_rd_ctrl #(
  parameter int BANK_NUM   = `SRAM_NUM,
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  orsram_rd_ctrl_if.master  bus
);

  localparam int         WORD_W  = BANK_NUM * DATA_W;
  localparam logic [2:0] CREDITS = 3'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W:0]   remaining;
  logic              inflight_p1;
  logic [WORD_W-1:0] fifo_mem [FIFO_DEPTH];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        fifo_cnt;
  logic [2:0]        credit;
  logic              issue;
  logic              push;
  logic              pop;
  logic              accept;
  logic              last_issue;

  assign accept     = (state == IDLE) && start;
  assign pop        = bus.out_valid && bus.out_ready;
  assign push       = inflight_p1;
  assign last_issue = issue && (remaining == (ADDR_W+1)'(1));

  // Words already committed to the FIFO: stored ones plus the one whose Q
  // arrives next edge. A slot freed by this cycle's pop may be reused.
  assign credit = {1'b0, fifo_cnt} + {2'b00, inflight_p1};

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = (len == '0) ? DONE : READ;
      READ:    if (last_issue) state_nxt = DRAIN;
      // Finish in the cycle that hands off the last word.
      DRAIN:   if (!inflight_p1 && (fifo_cnt == {1'b0, pop})) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    issue = 1'b0;
    unique case (state)
      IDLE:  busy = start;
      READ: begin
        busy  = 1'b1;
        issue = (credit < (CREDITS + {2'b00, pop}));
      end
      DRAIN: busy = 1'b1;
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign bus.sram_CEN = ~issue;
  assign bus.sram_WEN = '1;
  assign bus.sram_A   = issue ? {BANK_NUM{cur_addr}} : '0;

  // ---- stage p0: address generation / read issue ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr  <= '0;
      remaining <= '0;
    end else if (accept) begin
      cur_addr  <= base_addr;
      remaining <= len;
    end else if (issue) begin
      cur_addr  <= cur_addr + ADDR_W'(1);
      remaining <= remaining - (ADDR_W+1)'(1);
    end
  end

  // ---- stage p1: SRAM access in flight, Q captured into the FIFO ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_p1 <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      inflight_p1 <= issue;
      if (push) begin
        fifo_mem[wr_ptr] <= bus.sram_Q;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // ---- stage p2: FIFO head presented downstream (register outputs) ----
  assign bus.out_valid = (fifo_cnt != 2'd0);
  assign bus.out_data  = fifo_mem[rd_ptr];

`ifdef ORSRAM_RD_LAST_EN
  logic last_p1;
  logic fifo_last [FIFO_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_p1 <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_last[i] <= 1'b0;
    end else begin
      last_p1 <= last_issue;
      if (push) fifo_last[wr_ptr] <= last_p1;
    end
  end

  assign bus.out_last = fifo_last[rd_ptr];
`endif

endmodule

// File: tb/tb_orsram_rd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_orsram_rd_ctrl
// Scoreboard bench for orsram_rd_ctrl: stimulus pushes expected words into a
// queue, an independent monitor pops and compares on each handshake and also
// watches the SRAM port, stall stability and done/busy behaviour.
// Bank i holds mem[a] = a ^ i.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_orsram_rd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [6:0] base_addr;
  logic [7:0] len;
  logic       busy;
  logic       done;

  orsram_rd_ctrl_if #(.BANK_NUM(8), .ADDR_W(7), .DATA_W(8)) bus ();

  orsram_rd_ctrl #(.BANK_NUM(8), .ADDR_W(7), .DATA_W(8), .FIFO_DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM bank model: Q valid one cycle after a CEN=0 edge
  logic [7:0] mem [8][128];
  initial begin
    for (int i = 0; i < 8; i++)
      for (int a = 0; a < 128; a++) mem[i][a] = 8'(a ^ i);
  end
  always @(posedge clk) begin
    if (!bus.sram_CEN)
      for (int i = 0; i < 8; i++) bus.sram_Q[i*8 +: 8] <= mem[i][bus.sram_A[i*7 +: 7]];
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [63:0] exp_word(input logic [6:0] a);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[i*8 +: 8] = {1'b0, a} ^ 8'(i);
    return w;
  endfunction

  // Scoreboard state shared between stimulus and monitor
  logic [63:0] exp_q [$];
  bit          exp_last [$];
  int          outstanding = 0;
  bit          stall_pending = 0;
  logic [63:0] stall_data;
  bit          seen_valid = 0;
  int          first_valid_cyc = 0;
  int          start_cyc = 0;
  int          last_pop_cyc = 0;
  int          done_cyc = 0;
  int          done_cnt = 0;
  int          issue_cnt = 0;
  int          valid_cnt = 0;

  // out_ready driver
  bit   bp_en = 0;
  bit   pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  int   pat_idx = 0;
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (bp_en) begin
        bus.out_ready = pat[pat_idx];
        pat_idx = (pat_idx + 1) % 6;
      end else begin
        bus.out_ready = 1'b1;
        pat_idx = 0;
      end
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        bit          pop;
        bit          ok;
        logic [63:0] ew;
        bit          el;
        pop = bus.out_valid && bus.out_ready;
        if (bus.out_valid) valid_cnt++;
        if (bus.out_valid && !seen_valid) begin
          seen_valid      = 1;
          first_valid_cyc = cyc;
        end
        if (stall_pending) begin
          check("stall_valid", bus.out_valid, 1'b1);
          check("stall_data", bus.out_data, stall_data);
        end
        stall_pending = bus.out_valid && !bus.out_ready;
        stall_data    = bus.out_data;
        if (pop) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", bus.out_data, 64'hx);
          end else begin
            ew = exp_q.pop_front();
            el = exp_last.pop_front();
            check("word", bus.out_data, ew);
`ifdef ORSRAM_RD_LAST_EN
            check("last", bus.out_last, el);
`endif
          end
          last_pop_cyc = cyc;
        end
        if (!bus.sram_CEN) begin
          issue_cnt++;
          check("credit", ((outstanding + 1 - int'(pop)) <= 2), 1'b1);
          ok = 1;
          for (int i = 1; i < 8; i++)
            if (bus.sram_A[i*7 +: 7] !== bus.sram_A[6:0]) ok = 0;
          check("addr_repl", ok, 1'b1);
        end
        check("wen_high", bus.sram_WEN, 8'hFF);
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          check("busy_at_done", busy, 1'b0);
        end
        outstanding = outstanding + int'(!bus.sram_CEN) - int'(pop);
      end
    end
  end

  task automatic push_range(input logic [6:0] b, input int l);
    for (int k = 0; k < l; k++) begin
      exp_q.push_back(exp_word(7'(int'(b) + k)));
      exp_last.push_back(k == l - 1);
    end
  endtask

  task automatic start_burst(input logic [6:0] b, input logic [7:0] l);
    @(negedge clk);
    base_addr  = b;
    len        = l;
    start      = 1'b1;
    seen_valid = 0;
    start_cyc  = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input bit chk_lat);
    int d0  = done_cnt;
    bit got = 0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      #2;
      if (done_cnt != d0) got = 1;
    end
    check({name, "_done_seen"}, got, 1'b1);
    check({name, "_all_words"}, exp_q.size(), 0);
    check({name, "_done_gap"}, done_cyc - last_pop_cyc, 1);
    if (chk_lat) check({name, "_latency"}, first_valid_cyc - start_cyc, 3);
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_done"}, done, 1'b0);
    check({name, "_cen"}, bus.sram_CEN, 1'b1);
    check({name, "_wen"}, bus.sram_WEN, 8'hFF);
    check({name, "_addr"}, bus.sram_A, 56'h0);
    check({name, "_valid"}, bus.out_valid, 1'b0);
    check({name, "_data"}, bus.out_data, 64'h0);
`ifdef ORSRAM_RD_LAST_EN
    check({name, "_last"}, bus.out_last, 1'b0);
`endif
  endtask

  initial begin
    int i0;
    int v0;
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_state("por");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a burst, then a fresh short burst
    push_range(7'd0, 10);
    start_burst(7'd0, 8'd10);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_state("midrst");
    exp_q.delete();
    exp_last.delete();
    outstanding   = 0;
    stall_pending = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(64'h0405060700010203);
    exp_last.push_back(1'b0);
    exp_q.push_back(64'h0302010007060504);
    exp_last.push_back(1'b1);
    start_burst(7'd3, 8'd2);
    wait_done("rst_resume", 1);

    // Streaming across the address wrap
    i0 = issue_cnt;
    push_range(7'd120, 16);
    start_burst(7'd120, 8'd16);
    wait_done("wrap", 1);
    check("wrap_issues", issue_cnt - i0, 16);

    // Backpressure pattern on out_ready
    bp_en = 1;
    i0 = issue_cnt;
    push_range(7'd20, 8);
    start_burst(7'd20, 8'd8);
    wait_done("bp", 1);
    check("bp_issues", issue_cnt - i0, 8);
    bp_en = 0;

    // Zero-length burst
    i0 = issue_cnt;
    v0 = valid_cnt;
    @(negedge clk);
    base_addr = 7'd5;
    len       = 8'd0;
    start     = 1'b1;
    #1;
    check("len0_busy_start", busy, 1'b1);
    check("len0_cen", bus.sram_CEN, 1'b1);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("len0_done", done, 1'b1);
    check("len0_busy_done", busy, 1'b0);
    @(negedge clk);
    #1;
    check("len0_done_once", done, 1'b0);
    check("len0_no_issue", issue_cnt - i0, 0);
    check("len0_no_valid", valid_cnt - v0, 0);

    // Start while busy must be ignored
    i0 = issue_cnt;
    push_range(7'd10, 4);
    start_burst(7'd10, 8'd4);
    base_addr = 7'd50;
    len       = 8'd4;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start", 0);
    check("busy_start_issues", issue_cnt - i0, 4);

    // Full address range (last tag checked per word when enabled)
    i0 = issue_cnt;
    push_range(7'd0, 128);
    start_burst(7'd0, 8'd128);
    wait_done("full", 1);
    check("full_issues", issue_cnt - i0, 128);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
